// File: rtl/fir_rr_if.sv
// Sample/config/result bundle for fir_rr_scheduler.
// master = sample sources, coefficient writer and result consumer; slave = the scheduler.
interface fir_rr_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned NTAPS = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TAW = $clog2(NTAPS);

    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              cfg_we;
    logic [TAW-1:0]    cfg_addr;
    logic [CW-1:0]     cfg_data;
    logic              out_valid;
    logic [CHW-1:0]    out_ch;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              busy;

    modport master (
        output in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, busy
    );
endinterface

// File: rtl/fir_rr_scheduler.sv
// Round-robin shared serial-MAC FIR: one tap per cycle, per-channel delay lines, programmable coefs.
// Optional FIR_SAT_EN: unsigned saturation of the result instead of wrap-around truncation.
module fir_rr_scheduler #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned NTAPS = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 8
) (
    input  logic      CLK,
    input  logic      reset,
    fir_rr_if.slave   bus
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TAW = $clog2(NTAPS);
    localparam int unsigned AW  = DW + CW + $clog2(NTAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CHW-1:0]  r_rr;
    logic [CHW-1:0]  r_ch;
    logic [TAW-1:0]  r_k;
    logic [AW-1:0]   r_acc;
    logic [DW-1:0]   r_tap  [NCH][NTAPS];
    logic [CW-1:0]   r_coef [NTAPS];
    logic            r_out_valid;
    logic [CHW-1:0]  r_out_ch;
    logic [DW-1:0]   r_out_data;

    logic            w_gnt_vld;
    logic [CHW-1:0]  w_gnt;
    logic [NCH-1:0]  w_in_ready;
    logic [AW-1:0]   w_sum;
    logic [DW-1:0]   w_result;
    logic            w_cfg_ok;

    // First valid channel strictly after the rr pointer, wrapping around.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            if (!w_gnt_vld && bus.in_valid[(int'(r_rr) + i) % int'(NCH)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = CHW'((int'(r_rr) + i) % int'(NCH));
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        if (r_state == IDLE && w_gnt_vld) begin
            w_in_ready[w_gnt] = 1'b1;
        end
    end

    assign w_sum    = r_acc + AW'(r_tap[r_ch][r_k]) * AW'(r_coef[r_k]);
    assign w_cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_addr} < (TAW+1)'(NTAPS));

`ifdef FIR_SAT_EN
    assign w_result = (w_sum[AW-1:DW] != '0) ? {DW{1'b1}} : w_sum[DW-1:0];
`else
    assign w_result = w_sum[DW-1:0];
`endif

    // Sequencer, delay lines and coefficient bank.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr        <= CHW'(NCH - 1);
            r_ch        <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            for (int c = 0; c < int'(NCH); c++) begin
                for (int k = 0; k < int'(NTAPS); k++) begin
                    r_tap[c][k] <= '0;
                end
            end
            for (int k = 0; k < int'(NTAPS); k++) begin
                r_coef[k] <= CW'(int'(NTAPS) - k);
            end
        end else begin
            if (r_state == IDLE && w_cfg_ok) begin
                r_coef[bus.cfg_addr] <= bus.cfg_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_tap[w_gnt][0] <= bus.in_data[int'(w_gnt)*int'(DW) +: DW];
                        for (int k = 1; k < int'(NTAPS); k++) begin
                            r_tap[w_gnt][k] <= r_tap[w_gnt][k-1];
                        end
                        r_rr    <= w_gnt;
                        r_ch    <= w_gnt;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + TAW'(1);
                    if (r_k == TAW'(NTAPS - 1)) begin
                        r_out_data  <= w_result;
                        r_out_ch    <= r_ch;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != IDLE);
endmodule
